// File: rtl/read_slave.sv
// ============================================================================
//  Module   : read_slave
//  Purpose  : Burst read slave over a small internal word memory with a load
//             port. Optional macro READ_SLAVE_RESP_EN adds an r_resp output.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module read_slave #(
  parameter int MEM_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [MEM_AW-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              ar_valid,
  input  logic [31:0]       ar_addr,
  input  logic [3:0]        ar_len,
  output logic              ar_ready,
  output logic              r_valid,
  output logic [31:0]       r_data,
  output logic              r_last,
`ifdef READ_SLAVE_RESP_EN
  output logic [1:0]        r_resp,
`endif
  input  logic              r_ready
);

  localparam int         c_DEPTH = 1 << MEM_AW;
  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_BURST = 1'b1;

  logic [31:0]       r_mem [c_DEPTH];
  logic [0:0]        r_state;
  logic [MEM_AW-1:0] r_idx;     // word index of the next beat to load
  logic [3:0]        r_remain;  // beats still to load after the presented one
  logic              r_err;

  logic [MEM_AW-1:0] w_start_idx;
  logic              w_accept;
  logic              w_req_err;
  logic              w_unused_addr;

  assign w_start_idx = ar_addr[MEM_AW+1:2];
  assign w_accept    = (r_state == c_IDLE) && ar_ready && ar_valid;

`ifdef READ_SLAVE_RESP_EN
  assign w_req_err     = |ar_addr[31:MEM_AW+2];
  assign w_unused_addr = ^ar_addr[1:0];
`else
  assign w_req_err     = 1'b0;
  assign w_unused_addr = ^{ar_addr[31:MEM_AW+2], ar_addr[1:0]};
`endif

  // Load port is independent of the burst engine; reads see pre-write data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_IDLE;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_data   <= 32'd0;
      r_idx    <= '0;
      r_remain <= 4'd0;
      r_err    <= 1'b0;
`ifdef READ_SLAVE_RESP_EN
      r_resp   <= 2'b00;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          ar_ready <= 1'b1;
          if (w_accept) begin
            r_state  <= c_BURST;
            ar_ready <= 1'b0;
            r_valid  <= 1'b1;
            r_data   <= w_req_err ? 32'd0 : r_mem[w_start_idx];
            r_last   <= (ar_len == 4'd0);
            r_remain <= ar_len;
            r_idx    <= w_start_idx + 1'b1;
            r_err    <= w_req_err;
`ifdef READ_SLAVE_RESP_EN
            r_resp   <= w_req_err ? 2'b10 : 2'b00;
`endif
          end
        end
        c_BURST: begin
          if (r_ready) begin
            if (r_last) begin
              r_state  <= c_IDLE;
              r_valid  <= 1'b0;
              r_last   <= 1'b0;
              ar_ready <= 1'b1;
            end else begin
              r_data   <= r_err ? 32'd0 : r_mem[r_idx];
              r_idx    <= r_idx + 1'b1;
              r_remain <= r_remain - 4'd1;
              r_last   <= (r_remain == 4'd1);
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_read_slave.sv
// ============================================================================
//  Module   : tb_read_slave
//  Purpose  : Directed and random stimulus for read_slave against a
//             beat-queue reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_read_slave;

  localparam int MEM_AW = 4;
  localparam int DEPTH  = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [MEM_AW-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              ar_valid;
  logic [31:0]       ar_addr;
  logic [3:0]        ar_len;
  logic              ar_ready;
  logic              r_valid;
  logic [31:0]       r_data;
  logic              r_last;
  logic              r_ready;
`ifdef READ_SLAVE_RESP_EN
  logic [1:0]        r_resp;
`endif

  always #5 clk = ~clk;

  read_slave #(.MEM_AW(MEM_AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ar_valid (ar_valid),
    .ar_addr  (ar_addr),
    .ar_len   (ar_len),
    .ar_ready (ar_ready),
    .r_valid  (r_valid),
    .r_data   (r_data),
    .r_last   (r_last),
`ifdef READ_SLAVE_RESP_EN
    .r_resp   (r_resp),
`endif
    .r_ready  (r_ready)
  );

  // Reference model: memory image plus a queue of word indices still owed.
  logic [31:0] mem_m [DEPTH];
  int          q[$];
  logic        m_ar_ready, m_valid, m_last, m_err, m_dk;
  logic [31:0] m_data;
  logic [1:0]  m_resp;
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    int idx;
    int idx0;
    if (reset) begin
      q.delete();
      m_ar_ready = 1'b0; m_valid = 1'b0; m_last = 1'b0;
      m_data = 32'd0; m_resp = 2'b00; m_dk = 1'b1; m_err = 1'b0;
    end else if (m_valid) begin
      if (r_ready) begin
        if (q.size() == 0) begin
          m_valid = 1'b0; m_last = 1'b0; m_ar_ready = 1'b1; m_dk = 1'b0;
        end else begin
          idx    = q.pop_front();
          m_data = m_err ? 32'd0 : mem_m[idx];
          m_last = (q.size() == 0);
        end
      end
    end else if (m_ar_ready && ar_valid) begin
      idx0 = int'(ar_addr[MEM_AW+1:2]);
`ifdef READ_SLAVE_RESP_EN
      m_err = ((ar_addr >> (MEM_AW + 2)) != 0);
`else
      m_err = 1'b0;
`endif
      q.delete();
      for (int k = 0; k <= int'(ar_len); k++) q.push_back((idx0 + k) % DEPTH);
      idx        = q.pop_front();
      m_data     = m_err ? 32'd0 : mem_m[idx];
      m_last     = (q.size() == 0);
      m_valid    = 1'b1;
      m_ar_ready = 1'b0;
      m_resp     = m_err ? 2'b10 : 2'b00;
      m_dk       = 1'b1;
    end else begin
      m_ar_ready = 1'b1;
    end
    if (wr_en) mem_m[wr_addr] = wr_data;
    @(posedge clk);
    #1;
    chk("ar_ready", {31'd0, ar_ready}, {31'd0, m_ar_ready});
    chk("r_valid",  {31'd0, r_valid},  {31'd0, m_valid});
    chk("r_last",   {31'd0, r_last},   {31'd0, m_last});
    if (m_dk) chk("r_data", r_data, m_data);
`ifdef READ_SLAVE_RESP_EN
    if (m_dk) chk("r_resp", {30'd0, r_resp}, {30'd0, m_resp});
`endif
  endtask

  logic [31:0] exp26 [4];

  initial begin
    exp26[0] = 32'h100E; exp26[1] = 32'h100F; exp26[2] = 32'h1000; exp26[3] = 32'h1001;
    m_ar_ready = 1'b0; m_valid = 1'b0; m_last = 1'b0; m_err = 1'b0;
    m_data = 32'd0; m_resp = 2'b00; m_dk = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'hX;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = 32'd0;
    ar_valid = 1'b0; ar_addr = 32'd0; ar_len = 4'd0; r_ready = 1'b0;
    step(); step();
    chk("reset_ar_ready", {31'd0, ar_ready}, 32'd0);
    reset = 1'b0;
    step();
    chk("ar_ready_after_reset", {31'd0, ar_ready}, 32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = MEM_AW'(i); wr_data = 32'h1000 + i;
      step();
    end
    wr_en = 1'b0;

    // Single beat read
    ar_valid = 1'b1; ar_addr = 32'h8; ar_len = 4'd0; r_ready = 1'b1;
    step();
    chk("single_data", r_data, 32'h1002);
    chk("single_last", {31'd0, r_last}, 32'd1);
    ar_valid = 1'b0;
    step();
    chk("single_ready_back", {31'd0, ar_ready}, 32'd1);

    // Wrapping burst
    ar_valid = 1'b1; ar_addr = 32'h38; ar_len = 4'd3;
    for (int b = 0; b < 4; b++) begin
      step();
      ar_valid = 1'b0;
      chk("wrap_data", r_data, exp26[b]);
    end
    step();

    // Backpressure with ignored ar_valid pulses
    ar_valid = 1'b1; ar_addr = 32'h10; ar_len = 4'd1; r_ready = 1'b0;
    step();
    ar_addr = 32'h20;
    for (int c = 0; c < 5; c++) begin
      ar_valid = $urandom_range(0, 1);
      step();
      chk("hold_data", r_data, 32'h1004);
    end
    ar_valid = 1'b0; r_ready = 1'b1;
    step();
    chk("hold_next", r_data, 32'h1005);
    step();

    // Read-before-write on the loading edge
    ar_valid = 1'b1; ar_addr = 32'h8; ar_len = 4'd1;
    step();
    ar_valid = 1'b0; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEAD;
    step();
    chk("rbw_old", r_data, 32'h1003);
    wr_en = 1'b0;
    step();
    ar_valid = 1'b1; ar_addr = 32'hC; ar_len = 4'd0;
    step();
    chk("rbw_new", r_data, 32'hDEAD);
    ar_valid = 1'b0;
    step();

    // Reset mid-burst
    ar_valid = 1'b1; ar_addr = 32'h0; ar_len = 4'd7;
    step();
    ar_valid = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    chk("midrst_valid", {31'd0, r_valid}, 32'd0);
    chk("midrst_data", r_data, 32'd0);
    reset = 1'b0;
    step();
    chk("midrst_ready", {31'd0, ar_ready}, 32'd1);

`ifdef READ_SLAVE_RESP_EN
    ar_valid = 1'b1; ar_addr = 32'h100; ar_len = 4'd1;
    step();
    chk("err_resp", {30'd0, r_resp}, 32'd2);
    ar_valid = 1'b0;
    step();
    chk("err_data", r_data, 32'd0);
    step();
    ar_valid = 1'b1; ar_addr = 32'h4; ar_len = 4'd0;
    step();
    chk("ok_resp", {30'd0, r_resp}, 32'd0);
    chk("ok_data", r_data, 32'h1001);
    ar_valid = 1'b0;
    step();
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 59) == 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = MEM_AW'($urandom);
      wr_data  = $urandom;
      ar_valid = $urandom_range(0, 1);
      ar_addr  = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 255)));
      ar_len   = 4'($urandom);
      r_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    reset = 1'b0; ar_valid = 1'b0; wr_en = 1'b0; r_ready = 1'b1;
    for (int n = 0; n < 20; n++) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/read_slave.md
READ_SLAVE -- requirements
Module: read_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 4, word-address width of the internal memory (2**MEM_AW 32-bit words).
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports wr_en  input  1, wr_addr  input  MEM_AW, wr_data  input  32: memory load port; writes word wr_addr when wr_en=1.
REQ-005 SHALL have ports ar_valid  input  1, ar_addr  input  32 (byte address), ar_len  input  4 (beats minus 1): read request from master.
REQ-006 SHALL have port ar_ready  output  1  request accept, registered.
REQ-007 SHALL have ports r_valid  output  1, r_data  output  32, r_last  output  1: read data to master, all registered.
REQ-008 SHALL have port r_ready  input  1  master accepts beat.

Function
REQ-009 SHALL implement FSM IDLE/BURST; IDLE: ar_ready=1, r_valid=0; BURST: ar_ready=0, r_valid=1.
REQ-010 SHALL accept a request on a clock edge with ar_valid=1 and ar_ready=1, capturing word index ar_addr[MEM_AW+1:2] and beat count ar_len+1 (1..16), and enter BURST.
REQ-011 SHALL present beat 0 with r_valid=1 on the cycle after acceptance (1-cycle latency).
REQ-012 SHALL, while r_valid=1 and r_ready=0, hold r_data and r_last unchanged.
REQ-013 SHALL, on each r_valid&&r_ready edge not the last beat, load the next beat: word index +1, wrapping modulo 2**MEM_AW (index 15 -> 0 with MEM_AW=4).
REQ-014 SHALL assert r_last exactly on the final beat; ar_len=0 gives single beat with r_last=1.
REQ-015 SHALL, on the final-beat handshake, return to IDLE: r_valid=0, r_last=0, ar_ready=1 on the following cycle (no back-to-back overlap).
REQ-016 SHALL ignore ar_valid during BURST; ar_addr[1:0] ignored.
REQ-017 SHALL register r_data from memory when a beat is loaded; a write to the same word on the same edge returns old data (read-before-write); later writes do not alter a presented beat.
REQ-018 SHALL accept wr_en writes in any state, including BURST.

Reset
REQ-019 SHALL, on reset=1 at a clock edge, set state IDLE, ar_ready=0, r_valid=0, r_last=0, r_data=0, beat counter 0; memory contents unchanged.
REQ-020 SHALL drive ar_ready=1 on the first edge after reset deasserts.
REQ-021 SHALL, on reset mid-burst, abandon the burst with no further beats.

Configuration
REQ-022 SHALL, with macro READ_SLAVE_RESP_EN defined, add port r_resp  output  2, registered, reset 0, stable with r_data.
REQ-023 SHALL, with READ_SLAVE_RESP_EN defined, return r_resp=2'b00 (OKAY) when captured ar_addr[31:MEM_AW+2]==0, else r_resp=2'b10 (SLVERR) with r_data=0 for every beat of the burst, same beat count and r_last.
REQ-024 SHALL, without READ_SLAVE_RESP_EN, omit r_resp and ignore ar_addr[31:MEM_AW+2].

Verification
REQ-025 SHALL cover: load words 0..15 = 32'h1000+i; ar_addr=0x8, ar_len=0, r_ready=1 -> next cycle r_valid=1, r_data=0x1002, r_last=1; ar_ready=1 two cycles after accept.
REQ-026 SHALL cover: ar_addr=0x38, ar_len=3, r_ready=1 -> beats 0x100E, 0x100F, 0x1000, 0x1001 on consecutive cycles, r_last only on 0x1001.
REQ-027 SHALL cover: ar_len=1, r_ready=0 for 5 cycles then 1 -> r_data=beat 0 held stable all 5 cycles, ar_valid pulses during burst ignored.
REQ-028 SHALL cover: write word 3 = 0xDEAD on same edge beat at index 3 loads -> r_data=old 0x1003; subsequent read of index 3 returns 0xDEAD.
REQ-029 SHALL cover: reset asserted on beat 2 of ar_len=7 burst -> r_valid=0, r_data=0, ar_ready=0 next cycle, ar_ready=1 one cycle after release.
REQ-030 SHALL cover, with READ_SLAVE_RESP_EN: ar_addr=0x100, ar_len=1 -> two beats r_resp=2'b10, r_data=0; ar_addr=0x4 -> r_resp=2'b00, r_data=0x1001.
